// File: rtl/wb_pulse_gen_if.sv
// Wishbone-style register bus shared between a bus master and wb_pulse_gen.
//
// Handshake: the master raises i_stb together with i_we, i_adr and i_dat.
// The slave accepts the request in the cycle it sees i_stb while idle.
// It answers with o_ack high for exactly one cycle, the cycle after acceptance.
// o_dat carries read data only while o_ack is high and is zero otherwise.
// If the master keeps i_stb high through the ack cycle, that is a new request.
// A held strobe is therefore acked every second cycle.
interface wb_pulse_gen_if #(
  parameter int DSIZE = 8,
  parameter int AW    = 4
);
  logic             i_stb;
  logic             i_we;
  logic [AW-1:0]    i_adr;
  logic [DSIZE-1:0] i_dat;
  logic             o_ack;
  logic [DSIZE-1:0] o_dat;

  modport master (output i_stb, i_we, i_adr, i_dat, input o_ack, o_dat);
  modport slave  (input i_stb, i_we, i_adr, i_dat, output o_ack, o_dat);
endinterface

// File: rtl/wb_pulse_gen.sv
// Multi-channel Wishbone-programmable pulse generator.
// Each channel has a down-counter with a period, an enable and a one-shot mode.
// Counting advances only on the shared tick i_e.
// Per-channel registers, addressed by i_adr[1:0]:
//   0 CTRL   [0] EN, [1] ONESHOT, [2] IE
//   1 PERIOD
//   2 COUNT  (read-only)
//   3 STATUS (W1C sticky pulse flag)
// Optional macro PULSE_IRQ_EN enables the STATUS flag, CTRL.IE and o_irq.
// Without it, STATUS and IE read 0 and o_irq is tied low.
module wb_pulse_gen #(
  parameter  int DSIZE = 8,
  parameter  int NCH   = 4,
  localparam int AW    = $clog2(NCH) + 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_e,
  wb_pulse_gen_if.slave  bus,
  output logic [NCH-1:0] o_pulse,
  output logic           o_irq,
  output logic           bus_state
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    adr_q;
  logic             we_q;
  logic [DSIZE-1:0] dat_q;
  logic [DSIZE-1:0] rdata_q;
  logic [DSIZE-1:0] rd_mux;
  logic [AW-1:0]    ch_in;
  logic [AW-1:0]    ch_q;

  logic [DSIZE-1:0] period [NCH];
  logic [DSIZE-1:0] count  [NCH];
  logic [NCH-1:0]   en, oneshot, ie, flag;
  logic [NCH-1:0]   wr_ctrl, wr_per, wr_stat;
  logic [NCH-1:0]   fire, pulse_q;

  assign bus_state = (state_q == ACCESS);
  assign bus.o_ack = (state_q == ACCESS);
  assign bus.o_dat = (state_q == ACCESS) ? rdata_q : '0;
  assign o_pulse   = pulse_q;
  assign ch_q      = adr_q >> 2;

  // Bus FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Bus FSM next state: accept in IDLE, acknowledge for one cycle in ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_stb) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request and snapshot read data when a strobe is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      rdata_q <= '0;
    end else if (state_q == IDLE && bus.i_stb) begin
      adr_q   <= bus.i_adr;
      we_q    <= bus.i_we;
      dat_q   <= bus.i_dat;
      rdata_q <= bus.i_we ? '0 : rd_mux;
    end
  end

  // Read mux on the live address; out-of-range channels return zero.
  always_comb begin
    rd_mux = '0;
    ch_in  = bus.i_adr >> 2;
    for (int c = 0; c < NCH; c++) begin
      if (ch_in == AW'(c)) begin
        case (bus.i_adr[1:0])
          2'd0:    rd_mux = DSIZE'({ie[c], oneshot[c], en[c]});
          2'd1:    rd_mux = period[c];
          2'd2:    rd_mux = count[c];
          default: rd_mux = DSIZE'(flag[c]);
        endcase
      end
    end
  end

  // Write decode: a write commits at the end of the ACCESS cycle.
  always_comb begin
    wr_ctrl = '0;
    wr_per  = '0;
    wr_stat = '0;
    for (int c = 0; c < NCH; c++) begin
      if (state_q == ACCESS && we_q && ch_q == AW'(c)) begin
        wr_ctrl[c] = (adr_q[1:0] == 2'd0);
        wr_per[c]  = (adr_q[1:0] == 2'd1);
        wr_stat[c] = (adr_q[1:0] == 2'd3);
      end
    end
  end

  // Terminal tick per channel; a same-cycle PERIOD/CTRL write suppresses it.
  always_comb begin
    fire = '0;
    for (int c = 0; c < NCH; c++) begin
      fire[c] = !wr_per[c] && !wr_ctrl[c] && en[c] && (period[c] != '0) &&
                i_e && (count[c] == DSIZE'(1));
    end
  end

  // Per-channel registers, counters and the registered pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en      <= '0;
      oneshot <= '0;
      pulse_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        period[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      pulse_q <= fire;
      for (int c = 0; c < NCH; c++) begin
        if (wr_per[c]) begin
          period[c] <= dat_q;
          count[c]  <= dat_q;
        end else if (wr_ctrl[c]) begin
          en[c]      <= dat_q[0];
          oneshot[c] <= dat_q[1];
          if (dat_q[0]) count[c] <= period[c];
        end else if (en[c] && period[c] != '0 && i_e) begin
          if (fire[c]) begin
            if (oneshot[c]) begin
              count[c] <= '0;
              en[c]    <= 1'b0;
            end else begin
              count[c] <= period[c];
            end
          end else if (count[c] == '0) begin
            // Reached only if PERIOD became nonzero without a reload.
            count[c] <= period[c];
          end else begin
            count[c] <= count[c] - DSIZE'(1);
          end
        end
      end
    end
  end

`ifdef PULSE_IRQ_EN
  // Interrupt enable, sticky pulse flag (set beats W1C) and registered irq.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ie    <= '0;
      flag  <= '0;
      o_irq <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_ctrl[c]) ie[c] <= dat_q[2];
        flag[c] <= fire[c] | (flag[c] & ~(wr_stat[c] & dat_q[0]));
      end
      o_irq <= |(flag & ie);
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^wr_stat;
  assign ie    = '0;
  assign flag  = '0;
  assign o_irq = 1'b0;
`endif

endmodule
